// File: rtl/iomem_router.sv
// Routes picosoc iomem transactions in one address page to up to four slave slots.
// Absent or hung slaves are terminated by a timeout that returns an error word.
module iomem_router #(
   parameter logic [7:0]  PAGE     = 8'h03,
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         m_valid,
   output logic         m_ready,
   input  logic [3:0]   m_wstrb,
   input  logic [31:0]  m_addr,
   input  logic [31:0]  m_wdata,
   output logic [31:0]  m_rdata,
   output logic [3:0]   s_valid,
   input  logic [3:0]   s_ready,
   output logic [3:0]   s_wstrb,
   output logic [31:0]  s_addr,
   output logic [31:0]  s_wdata,
   input  logic [127:0] s_rdata,
   input  logic         err_clr,
   output logic [7:0]   err_count,
   output logic         err_flag
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

   state_t      r_state, w_state;
   logic [1:0]  r_sel, w_sel;
   logic [15:0] r_cnt, w_cnt;
   logic        r_m_ready, w_m_ready;
   logic [31:0] r_m_rdata, w_m_rdata;
   logic [3:0]  r_s_valid, w_s_valid;
   logic [3:0]  r_s_wstrb, w_s_wstrb;
   logic [31:0] r_s_addr, w_s_addr;
   logic [31:0] r_s_wdata, w_s_wdata;
   logic [7:0]  r_err_count, w_err_count;
   logic        r_err_flag, w_err_flag;
   logic        w_err;
   logic        w_hit;
   logic [6:0]  w_rd_lsb;

   // !r_m_ready keeps the transaction just answered from being accepted a second time.
   assign w_hit    = m_valid && !r_m_ready && (m_addr[31:24] == PAGE);
   assign w_rd_lsb = {r_sel, 5'd0};

   always_comb begin
      w_state     = r_state;
      w_sel       = r_sel;
      w_cnt       = r_cnt;
      w_m_ready   = 1'b0;
      w_m_rdata   = r_m_rdata;
      w_s_valid   = r_s_valid;
      w_s_wstrb   = r_s_wstrb;
      w_s_addr    = r_s_addr;
      w_s_wdata   = r_s_wdata;
      w_err_count = r_err_count;
      w_err_flag  = r_err_flag;
      w_err       = 1'b0;

      case (r_state)
         StIdle: begin
            if (w_hit) begin
               w_s_addr  = m_addr;
               w_s_wdata = m_wdata;
               w_s_wstrb = m_wstrb;
               w_sel     = m_addr[21:20];
               if (m_addr[23:22] != 2'b00) begin
                  w_m_rdata = ERR_DATA;
                  w_err     = 1'b1;
                  w_state   = StResp;
               end else begin
                  w_s_valid = 4'b0001 << m_addr[21:20];
                  w_cnt     = 16'd0;
                  w_state   = StBusy;
               end
            end
         end
         StBusy: begin
            w_cnt = r_cnt + 16'd1;
            // A ready arriving on the expiry cycle still wins over the timeout.
            if (s_ready[r_sel]) begin
               w_m_rdata = s_rdata[w_rd_lsb +: 32];
               w_s_valid = 4'b0000;
               w_state   = StResp;
            end else if (r_cnt == LAST_CNT) begin
               w_m_rdata = ERR_DATA;
               w_s_valid = 4'b0000;
               w_err     = 1'b1;
               w_state   = StResp;
            end
         end
         StResp: begin
            w_m_ready = 1'b1;
            w_state   = StIdle;
         end
         default: begin
            w_s_valid = 4'b0000;
            w_state   = StIdle;
         end
      endcase

      if (err_clr) begin
         w_err_count = w_err ? 8'd1 : 8'd0;
         w_err_flag  = w_err;
      end else if (w_err) begin
         w_err_flag = 1'b1;
         if (r_err_count != 8'hFF) w_err_count = r_err_count + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_sel       <= 2'd0;
         r_cnt       <= 16'd0;
         r_m_ready   <= 1'b0;
         r_m_rdata   <= 32'd0;
         r_s_valid   <= 4'd0;
         r_s_wstrb   <= 4'd0;
         r_s_addr    <= 32'd0;
         r_s_wdata   <= 32'd0;
         r_err_count <= 8'd0;
         r_err_flag  <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_sel       <= w_sel;
         r_cnt       <= w_cnt;
         r_m_ready   <= w_m_ready;
         r_m_rdata   <= w_m_rdata;
         r_s_valid   <= w_s_valid;
         r_s_wstrb   <= w_s_wstrb;
         r_s_addr    <= w_s_addr;
         r_s_wdata   <= w_s_wdata;
         r_err_count <= w_err_count;
         r_err_flag  <= w_err_flag;
      end
   end

   assign m_ready   = r_m_ready;
   assign m_rdata   = r_m_rdata;
   assign s_valid   = r_s_valid;
   assign s_wstrb   = r_s_wstrb;
   assign s_addr    = r_s_addr;
   assign s_wdata   = r_s_wdata;
   assign err_count = r_err_count;
   assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_iomem_router.sv
// Self-checking bench for iomem_router: directed scenarios plus randomized traffic,
// checked against a transaction-level model of latency, data and error counting.
module tb_iomem_router;

   localparam int unsigned TO  = 255;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic         clk = 1'b0;
   logic         resetn;
   logic         m_valid;
   logic         m_ready;
   logic [3:0]   m_wstrb;
   logic [31:0]  m_addr;
   logic [31:0]  m_wdata;
   logic [31:0]  m_rdata;
   logic [3:0]   s_valid;
   logic [3:0]   s_ready;
   logic [3:0]   s_wstrb;
   logic [31:0]  s_addr;
   logic [31:0]  s_wdata;
   logic [127:0] s_rdata;
   logic         err_clr;
   logic [7:0]   err_count;
   logic         err_flag;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;
   bit exp_flag = 0;

   iomem_router #(
      .PAGE     (8'h03),
      .TIMEOUT  (TO),
      .ERR_DATA (ERR)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_wstrb   (m_wstrb),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_wstrb   (s_wstrb),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rdata   (s_rdata),
      .err_clr   (err_clr),
      .err_count (err_count),
      .err_flag  (err_flag)
   );

   always #5 clk = ~clk;

   // delay = extra s_valid cycles before the slave readies; negative = slave never answers.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int delay,
                          input logic [31:0] rdv, input bit clr, input string name);
      logic [1:0]  sel;
      bit          dec, err, got, bad_hot;
      int          exp_vc, exp_lat, vc, lat;
      logic [31:0] exp_rd, got_rd;
      sel    = addr[21:20];
      dec    = (addr[23:22] != 2'b00);
      err    = dec || (delay < 0) || (delay >= int'(TO));
      exp_vc = dec ? 0 : (((delay < 0) || (delay >= int'(TO))) ? int'(TO) : delay + 1);
      exp_lat = exp_vc + 2;
      exp_rd = err ? ERR : rdv;
      if (clr) begin
         exp_cnt  = 0;
         exp_flag = 0;
      end
      if (err) begin
         exp_flag = 1;
         if (exp_cnt < 255) exp_cnt++;
      end

      @(negedge clk);
      m_valid = 1'b1;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
      err_clr = clr;
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      s_rdata[32*sel +: 32] = rdv;
      s_ready = 4'b0000;
      vc = 0; lat = 0; got = 0; bad_hot = 0; got_rd = '0;
      for (int n = 1; n <= 600 && !got; n++) begin
         @(negedge clk);
         err_clr = 1'b0;
         s_ready = 4'($urandom) & ~(4'b0001 << sel);
         if (s_valid != 4'b0000) begin
            if (s_valid !== (4'b0001 << sel)) bad_hot = 1;
            vc++;
            if (vc == 1) begin
               n_cmp++;
               if ({s_addr, s_wdata, s_wstrb} !== {addr, wdata, wstrb}) begin
                  n_bad++;
                  $display("FAIL %s fields: got addr=%h wdata=%h wstrb=%b want %h %h %b",
                           name, s_addr, s_wdata, s_wstrb, addr, wdata, wstrb);
               end
            end
            if (vc == delay + 1) s_ready[sel] = 1'b1;
         end
         if (m_ready === 1'b1) begin
            got    = 1;
            lat    = n;
            got_rd = m_rdata;
            m_valid = 1'b0;
         end
      end
      s_ready = 4'b0000;

      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s no_response: m_ready never rose within 600 cycles", name);
      end
      n_cmp++;
      if (lat != exp_lat) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      n_cmp++;
      if (vc != exp_vc || bad_hot) begin
         n_bad++;
         $display("FAIL %s s_valid: got %0d cycles (bad_onehot=%0d) want %0d",
                  name, vc, bad_hot, exp_vc);
      end
      n_cmp++;
      if (got_rd !== exp_rd) begin
         n_bad++;
         $display("FAIL %s rdata: got %h want %h", name, got_rd, exp_rd);
      end
      n_cmp++;
      if (err_count !== 8'(exp_cnt) || err_flag !== exp_flag) begin
         n_bad++;
         $display("FAIL %s err: got count=%0d flag=%0d want %0d %0d",
                  name, err_count, err_flag, exp_cnt, exp_flag);
      end
      @(negedge clk);
      n_cmp++;
      if (m_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL %s pulse: m_ready got %b want 0 after one cycle", name, m_ready);
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      s_ready = '0; s_rdata = '0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({m_ready, m_rdata, s_valid} !== 37'd0) begin
         n_bad++;
         $display("FAIL reset_master: got m_ready=%b m_rdata=%h s_valid=%b want 0",
                  m_ready, m_rdata, s_valid);
      end
      n_cmp++;
      if ({s_wstrb, s_addr, s_wdata, err_count, err_flag} !== 77'd0) begin
         n_bad++;
         $display("FAIL reset_slave: got wstrb=%b addr=%h wdata=%h cnt=%0d flag=%b want 0",
                  s_wstrb, s_addr, s_wdata, err_count, err_flag);
      end
      resetn = 1'b1;
      exp_cnt = 0; exp_flag = 0;
   endtask

   task automatic test_directed;
      run_txn(32'h0300_0000, 32'h0, 4'b0000, 1, 32'h0000_00A5, 0, "read_slot0");
      run_txn(32'h0320_0004, 32'h1234_5678, 4'b0011, 0, 32'h0, 0, "write_slot2");
      run_txn(32'h0340_0000, 32'h0, 4'b0000, 0, 32'h5555_5555, 0, "decode_err");
      run_txn(32'h0330_0000, 32'h0, 4'b0000, -1, 32'h7777_0000, 0, "timeout_slot3");
      run_txn(32'h0330_0010, 32'h0, 4'b0000, int'(TO) - 1, 32'h0BAD_CAFE, 0, "ready_at_expiry");
   endtask

   task automatic test_saturation;
      for (int i = 0; i < 260; i++)
         run_txn({8'h03, 2'(1 + $urandom_range(0, 2)), 22'($urandom)}, $urandom,
                 4'($urandom), 0, $urandom, 0, "sat_err");
      run_txn(32'h03C0_0000, 32'h0, 4'b0000, 0, 32'h0, 1, "clr_with_err");
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_cnt = 0; exp_flag = 0;
      n_cmp++;
      if (err_count !== 8'd0 || err_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_alone: got count=%0d flag=%b want 0 0", err_count, err_flag);
      end
   endtask

   task automatic test_out_of_page;
      bit seen = 0;
      @(negedge clk);
      m_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         m_addr = (i == 0) ? 32'h0200_0000 : {8'($urandom_range(4, 255)), 24'($urandom)};
         @(negedge clk);
         if (s_valid !== 4'b0000 || m_ready !== 1'b0) seen = 1;
      end
      m_valid = 1'b0;
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL out_of_page: got activity=1 want no s_valid and no m_ready");
      end
   endtask

   task automatic test_reset_mid_busy;
      bit stale = 0;
      @(negedge clk);
      m_valid = 1'b1; m_addr = 32'h0310_0000; m_wstrb = 4'b0000; s_ready = 4'b0000;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (s_valid !== 4'b0010) begin
         n_bad++;
         $display("FAIL busy_before_reset: s_valid got %b want 0010", s_valid);
      end
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if (s_valid !== 4'b0000 || m_ready !== 1'b0 || err_count !== 8'd0) begin
         n_bad++;
         $display("FAIL async_reset: got s_valid=%b m_ready=%b cnt=%0d want 0 0 0",
                  s_valid, m_ready, err_count);
      end
      m_valid = 1'b0;
      exp_cnt = 0; exp_flag = 0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (m_ready !== 1'b0) stale = 1;
      end
      n_cmp++;
      if (stale) begin
         n_bad++;
         $display("FAIL stale_ready: got m_ready=1 after reset want 0");
      end
      run_txn(32'h0310_0040, 32'hCAFE_F00D, 4'b1111, 2, 32'h1357_9BDF, 0, "after_reset");
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic [1:0] hi;
         int d;
         hi = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         d  = ($urandom_range(0, 12) == 0) ? -1 : int'($urandom_range(0, 6));
         run_txn({8'h03, hi, 2'($urandom), 20'($urandom)}, $urandom, 4'($urandom),
                 d, $urandom, 0, "random");
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_saturation;
      test_out_of_page;
      test_reset_mid_busy;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
